// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package sevseg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } phase_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Element 15 is listed first, so SEG_TABLE[n] is the code for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment code.
module hex7seg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame-synchronous
// content update (pending -> shadow only at the end of digit 7's slot).
//
// state | meaning
// SHOW  | current digit's anode driven (if enabled), segments show its nibble
// BLANK | all anodes off, segments off, guards against ghosting between digits
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  en_mask,
  output logic        busy,
  output logic        frame,
  output logic [6:0]  hex,
  output logic [7:0]  AN
);

  localparam int CMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);

  phase_t        phase, nxt_phase;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [2:0]    idx, nxt_idx;
  logic [31:0]   sh_data, nxt_sh_data, pend_data;
  logic [7:0]    sh_mask, nxt_sh_mask, pend_mask;
  logic          busy_q, frame_q;
  logic [6:0]    hex_q, nxt_hex;
  logic [7:0]    an_q, nxt_an;
  logic          boundary, nxt_frame, nxt_lit;
  logic [3:0]    nibble;
  logic [6:0]    seg_code;

  // Last cycle of a digit slot; with no blank phase the slot ends in SHOW.
  function automatic logic slot_end(input phase_t p, input logic [CW-1:0] c);
    if (BLANK_CYCLES == 0) return (p == SHOW) && (c == SHOW_LAST);
    else                   return (p == BLANK) && (c == BLANK_LAST);
  endfunction

  assign boundary = slot_end(phase, cnt) && (idx == 3'd7);

  always_comb begin
    nxt_phase   = phase;
    nxt_cnt     = cnt + 1'b1;
    nxt_idx     = idx;
    nxt_sh_data = sh_data;
    nxt_sh_mask = sh_mask;

    if (phase == SHOW && cnt == SHOW_LAST) begin
      nxt_cnt = '0;
      if (BLANK_CYCLES == 0) nxt_idx = idx + 3'd1;
      else                   nxt_phase = BLANK;
    end else if (phase == BLANK && cnt == BLANK_LAST) begin
      nxt_cnt   = '0;
      nxt_phase = SHOW;
      nxt_idx   = idx + 3'd1;
    end

    if (boundary) begin
      if (load) begin
        nxt_sh_data = data;
        nxt_sh_mask = en_mask;
      end else if (busy_q) begin
        nxt_sh_data = pend_data;
        nxt_sh_mask = pend_mask;
      end
    end

    // Outputs are computed from next state so they change on the phase-entry edge.
    nxt_lit   = (nxt_phase == SHOW) && nxt_sh_mask[nxt_idx];
    nibble    = nxt_sh_data[{nxt_idx, 2'b00} +: 4];
    nxt_an    = nxt_lit ? ~(8'b1 << nxt_idx) : AN_OFF;
    nxt_hex   = nxt_lit ? seg_code : SEG_BLANK;
    nxt_frame = slot_end(nxt_phase, nxt_cnt) && (nxt_idx == 3'd7);
  end

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg    (seg_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= SHOW;
      cnt       <= '0;
      idx       <= 3'd0;
      sh_data   <= '0;
      sh_mask   <= 8'h00;
      pend_data <= '0;
      pend_mask <= 8'h00;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= AN_OFF;
      hex_q     <= SEG_BLANK;
    end else begin
      phase   <= nxt_phase;
      cnt     <= nxt_cnt;
      idx     <= nxt_idx;
      sh_data <= nxt_sh_data;
      sh_mask <= nxt_sh_mask;
      if (!boundary && load) begin
        pend_data <= data;
        pend_mask <= en_mask;
      end
      if (boundary)  busy_q <= 1'b0;
      else if (load) busy_q <= 1'b1;
      frame_q <= nxt_frame;
      an_q    <= nxt_an;
      hex_q   <= nxt_hex;
    end
  end

  assign busy  = busy_q;
  assign frame = frame_q;
  assign hex   = hex_q;
  assign AN    = an_q;

endmodule
